// File: rtl/ffo_enum_ctrl_if.sv
// Bundle between the set-bit enumerator, its upstream/downstream users and the
// sequential find-first-one unit.
//   start/din        : request and vector from upstream
//   busy             : enumerator not idle
//   pos_valid/pos/pos_ack : position stream to the consumer
//   done/count/err   : end-of-run pulse, emitted count, sticky timeout flag
//   ffo_start/ffo_b  : search request and vector to the FFO unit
//   ffo_v/ffo_p/ffo_ready : FFO result
// Bit i of din/ffo_b is position i; position 0 is searched first.
interface ffo_enum_ctrl_if #(
    parameter int unsigned N = 32
);
    localparam int unsigned PW = $clog2(N);

    logic          start;
    logic [N-1:0]  din;
    logic          busy;
    logic          pos_valid;
    logic [PW-1:0] pos;
    logic          pos_ack;
    logic          done;
    logic [PW:0]   count;
    logic          err;
    logic          ffo_start;
    logic [N-1:0]  ffo_b;
    logic          ffo_v;
    logic [PW-1:0] ffo_p;
    logic          ffo_ready;

    // Environment side: upstream, consumer and FFO unit
    modport master (
        output start, din, pos_ack, ffo_v, ffo_p, ffo_ready,
        input  busy, pos_valid, pos, done, count, err, ffo_start, ffo_b
    );

    // Enumerator side
    modport slave (
        input  start, din, pos_ack, ffo_v, ffo_p, ffo_ready,
        output busy, pos_valid, pos, done, count, err, ffo_start, ffo_b
    );
endinterface

// File: rtl/ffo_enum_ctrl.sv
// Enumerates every set bit of a vector, lowest position first, by driving a
// sequential find-first-one unit and clearing each bit it reports.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   io_bus : ffo_enum_ctrl_if.slave (request, position stream, FFO unit)
module ffo_enum_ctrl #(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ffo_enum_ctrl_if.slave io_bus
);
    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [N-1:0]  r_work;
    logic [N-1:0]  w_work_clr;
    logic [PW-1:0] r_pos;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tmr;
    logic          r_busy;
    logic          r_pos_valid;
    logic          r_done;
    logic          r_err;
    logic          r_ffo_start;
    logic          w_accept;
    logic          w_hit;
    logic          w_ack;
    logic          w_timeout;
    logic          w_tmr_exp;

    // Last allowed cycle of a wait state
    assign w_tmr_exp = (r_tmr == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_hit      = 1'b0;
        w_ack      = 1'b0;
        w_timeout  = 1'b0;
        w_work_clr = r_work;
        w_work_clr[io_bus.ffo_p] = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nx = S_WAIT_LOW;
            S_WAIT_LOW: begin
                // A ready left over from the previous search must drop first
                if (!io_bus.ffo_ready) begin
                    w_state_nx = S_WAIT_HIGH;
                end else if (w_tmr_exp) begin
                    w_timeout  = 1'b1;
                    w_state_nx = S_FINISH;
                end
            end
            S_WAIT_HIGH: begin
                if (io_bus.ffo_ready) begin
                    if (io_bus.ffo_v) begin
                        w_hit      = 1'b1;
                        w_state_nx = S_EMIT;
                    end else begin
                        w_state_nx = S_FINISH;
                    end
                end else if (w_tmr_exp) begin
                    w_timeout  = 1'b1;
                    w_state_nx = S_FINISH;
                end
            end
            S_EMIT: begin
                // Empty work skips the search that would only report v=0
                if (io_bus.pos_ack) begin
                    w_ack      = 1'b1;
                    w_state_nx = (r_work == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_FINISH: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Datapath, wait timer and registered outputs decoded from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_work      <= '0;
            r_pos       <= '0;
            r_count     <= '0;
            r_tmr       <= '0;
            r_busy      <= 1'b0;
            r_pos_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ffo_start <= 1'b0;
        end else begin
            r_busy      <= (w_state_nx != S_IDLE);
            r_ffo_start <= (w_state_nx == S_LAUNCH);
            r_pos_valid <= (w_state_nx == S_EMIT);
            r_done      <= (w_state_nx == S_FINISH);
            if (w_accept) begin
                r_work  <= io_bus.din;
                r_count <= '0;
                r_err   <= 1'b0;
            end
            if (w_hit) begin
                r_pos  <= io_bus.ffo_p;
                r_work <= w_work_clr;
            end
            if (w_ack) begin
                r_count <= r_count + CW'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_state_nx != r_state) begin
                r_tmr <= '0;
            end else if (r_state == S_WAIT_LOW || r_state == S_WAIT_HIGH) begin
                r_tmr <= r_tmr + TW'(1);
            end
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.pos_valid = r_pos_valid;
    assign io_bus.pos       = r_pos;
    assign io_bus.done      = r_done;
    assign io_bus.count     = r_count;
    assign io_bus.err       = r_err;
    assign io_bus.ffo_start = r_ffo_start;
    assign io_bus.ffo_b     = r_work;
endmodule

// File: tb/tb_ffo_enum_ctrl.sv
// Randomized bench for ffo_enum_ctrl with a behavioural FFO unit, a consumer
// and a reference model built from the list of set bits of each request.
module tb_ffo_enum_ctrl;
    localparam int unsigned N       = 32;
    localparam int unsigned PW      = $clog2(N);
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ffo_enum_ctrl_if #(.N(N)) bus ();

    ffo_enum_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_starts, n_done, n_acc;
    int t_first_start, t_done, t_last_acc;
    int ack_mode, stall_left;
    bit stuck;
    int lat_lo = 2;
    int lat_hi = 5;
    int lat;
    bit ffo_busy;
    int q_exp[$];
    logic [N-1:0]  exp_work;
    bit            prev_valid, prev_acc;
    logic [PW-1:0] prev_pos;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] first_one(input logic [N-1:0] b);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) begin
                r = PW'(i);
                break;
            end
        end
        return r;
    endfunction

    // Behavioural FFO unit, consumer and position scoreboard
    initial begin
        int exp_p;
        bus.ffo_ready = 1'b1;
        bus.ffo_v     = 1'b0;
        bus.ffo_p     = '0;
        bus.pos_ack   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                ffo_busy      = 1'b0;
                bus.ffo_ready = 1'b1;
                prev_valid    = 1'b0;
                prev_acc      = 1'b0;
                continue;
            end
            if (bus.done) begin
                n_done++;
                t_done = cyc;
            end
            if (bus.ffo_start) begin
                n_starts++;
                if (n_starts == 1) t_first_start = cyc;
                check("ffo_b_at_launch", 64'(bus.ffo_b), 64'(exp_work));
                if (!stuck) begin
                    bus.ffo_ready = 1'b0;
                    ffo_busy      = 1'b1;
                    lat           = int'($urandom_range(lat_hi, lat_lo));
                end
            end else if (ffo_busy) begin
                lat--;
                if (lat == 0) begin
                    ffo_busy = 1'b0;
                    check("ffo_b_stable", 64'(bus.ffo_b), 64'(exp_work));
                    bus.ffo_v     = |bus.ffo_b;
                    bus.ffo_p     = first_one(bus.ffo_b);
                    bus.ffo_ready = 1'b1;
                end
            end
            case (ack_mode)
                0: bus.pos_ack = 1'b1;
                1: bus.pos_ack = 1'($urandom_range(1, 0));
                default: begin
                    if (bus.pos_valid && stall_left > 0) begin
                        bus.pos_ack = 1'b0;
                        stall_left--;
                    end else begin
                        bus.pos_ack = 1'b1;
                    end
                end
            endcase
            if (bus.pos_valid) begin
                check("no_launch_in_emit", 64'(bus.ffo_start), 64'(0));
                if (prev_valid && !prev_acc) check("pos_stable", 64'(bus.pos), 64'(prev_pos));
                if (bus.pos_ack) begin
                    exp_p = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
                    check("pos", 64'(bus.pos), 64'(exp_p));
                    if (exp_p >= 0) exp_work[exp_p] = 1'b0;
                    n_acc++;
                    t_last_acc = cyc;
                end
            end
            prev_valid = bus.pos_valid;
            prev_acc   = bus.pos_valid && bus.pos_ack;
            prev_pos   = bus.pos;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Load the reference model for a new request
    task automatic arm(input logic [N-1:0] d, input int mode, input bit stk);
        q_exp.delete();
        for (int i = 0; i < int'(N); i++) if (d[i]) q_exp.push_back(i);
        exp_work   = d;
        ack_mode   = mode;
        stall_left = 5;
        stuck      = stk;
        ffo_busy   = 1'b0;
        if (stk) bus.ffo_ready = 1'b1;
        n_starts   = 0;
        n_done     = 0;
        n_acc      = 0;
    endtask

    // Pulse start for one cycle; afterwards the bench sits in the LAUNCH cycle
    task automatic launch(input logic [N-1:0] d);
        bus.din   = d;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.din   = '0;
        check("busy_on_start", 64'(bus.busy), 64'(1));
        check("ffo_start_on_start", 64'(bus.ffo_start), 64'(1));
        check("err_cleared", 64'(bus.err), 64'(0));
        check("count_cleared", 64'(bus.count), 64'(0));
    endtask

    // tmo: 0 none, 1 ready stuck high, 2 FFO slower than TIMEOUT
    task automatic run(input logic [N-1:0] d, input int mode, input int tmo, input bit poke);
        int pc;
        int budget;
        arm(d, mode, tmo == 1);
        pc = q_exp.size();
        launch(d);
        if (poke) begin
            bus.din   = ~d;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            check("busy_start_ignored_work", 64'(bus.ffo_b), 64'(d));
            check("busy_start_ignored_count", 64'(bus.count), 64'(0));
        end
        budget = 0;
        while (n_done == 0 && budget < 4000) begin
            step();
            budget++;
        end
        check("done_seen", 64'(n_done), 64'(1));
        check("done_no_pos_valid", 64'(bus.pos_valid), 64'(0));
        check("busy_during_done", 64'(bus.busy), 64'(1));
        if (tmo != 0) begin
            check("timeout_err", 64'(bus.err), 64'(1));
            check("timeout_count", 64'(bus.count), 64'(0));
            check("timeout_searches", 64'(n_starts), 64'(1));
            check("timeout_latency", 64'(t_done - t_first_start),
                  64'((tmo == 1) ? TIMEOUT + 1 : TIMEOUT + 2));
        end else begin
            check("err", 64'(bus.err), 64'(0));
            check("count", 64'(bus.count), 64'(pc));
            check("accepted", 64'(n_acc), 64'(pc));
            check("searches", 64'(n_starts), 64'((pc == 0) ? 1 : pc));
            if (pc > 0) check("done_after_last_ack", 64'(t_done - t_last_acc), 64'(1));
        end
        step();
        check("busy_after_done", 64'(bus.busy), 64'(0));
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("count_held", 64'(bus.count), 64'((tmo != 0) ? 0 : pc));
    endtask

    initial begin
        logic [N-1:0] d;
        int budget;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.din   = '0;
        arm('0, 0, 1'b0);
        step();
        step();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_pos_valid", 64'(bus.pos_valid), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_err", 64'(bus.err), 64'(0));
        check("rst_ffo_start", 64'(bus.ffo_start), 64'(0));
        check("rst_pos", 64'(bus.pos), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_ffo_b", 64'(bus.ffo_b), 64'(0));
        rst = 1'b0;
        step();

        run('0, 0, 0, 1'b0);
        d = '0; d[3] = 1'b1; d[17] = 1'b1; d[31] = 1'b1;
        run(d, 0, 0, 1'b0);
        run('1, 0, 0, 1'b0);
        d = '0; d[5] = 1'b1; d[9] = 1'b1;
        run(d, 2, 0, 1'b0);
        run(N'($urandom) | N'(1), 0, 1, 1'b0);
        run(N'($urandom), 1, 0, 1'b0);
        lat_lo = 80; lat_hi = 80;
        run(N'($urandom) | N'(1), 0, 2, 1'b0);

        // Reset during the second search
        lat_lo = 6; lat_hi = 6;
        d = '0; d[4] = 1'b1; d[11] = 1'b1; d[25] = 1'b1;
        arm(d, 0, 1'b0);
        launch(d);
        budget = 0;
        while (n_starts < 2 && budget < 200) begin
            step();
            budget++;
        end
        check("second_search_seen", 64'(n_starts), 64'(2));
        step();
        step();
        step();
        check("count_before_reset", 64'(bus.count), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_pos_valid", 64'(bus.pos_valid), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        check("midrst_ffo_start", 64'(bus.ffo_start), 64'(0));
        check("midrst_count", 64'(bus.count), 64'(0));
        check("midrst_ffo_b", 64'(bus.ffo_b), 64'(0));
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("midrst_no_done", 64'(n_done), 64'(0));
        check("midrst_no_search", 64'(n_starts), 64'(2));

        lat_lo = 2; lat_hi = 5;
        run(N'($urandom) | N'(1 << 7), 1, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run(N'($urandom) & N'($urandom), 1, 0, 1'(k & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
